// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_arbiter_pkg;
    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);

    // Round-robin pointer encodings: which requester wins when both are valid.
    localparam logic PRIO_LD  = 1'b1;
    localparam logic PRIO_ALU = 1'b0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of all writeback-arbiter signals: ALU and load requesters, load-issue
// scoreboard inputs, hazard query, regfile write port and busy debug vector.
// slave = arbiter side, master = requesters/issue stage/regfile side.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic             i_AluValid;
    logic             o_AluReady;
    reg_idx_t         i_AluReg;
    xdata_t           i_AluData;
    logic             i_LdValid;
    logic             o_LdReady;
    reg_idx_t         i_LdReg;
    xdata_t           i_LdData;
    logic             i_LdIssue;
    reg_idx_t         i_LdIssueReg;
    reg_idx_t         i_ReadReg1;
    reg_idx_t         i_ReadReg2;
    reg_idx_t         i_DestReg;
    logic             o_Hazard;
    logic             o_RegWrite;
    reg_idx_t         o_WriteReg;
    xdata_t           o_WriteData;
    logic [NREGS-1:0] o_Busy;

    modport slave (
        input  i_AluValid, i_AluReg, i_AluData,
        input  i_LdValid, i_LdReg, i_LdData,
        input  i_LdIssue, i_LdIssueReg,
        input  i_ReadReg1, i_ReadReg2, i_DestReg,
        output o_AluReady, o_LdReady, o_Hazard,
        output o_RegWrite, o_WriteReg, o_WriteData, o_Busy
    );

    modport master (
        output i_AluValid, i_AluReg, i_AluData,
        output i_LdValid, i_LdReg, i_LdData,
        output i_LdIssue, i_LdIssueReg,
        output i_ReadReg1, i_ReadReg2, i_DestReg,
        input  o_AluReady, o_LdReady, o_Hazard,
        input  o_RegWrite, o_WriteReg, o_WriteData, o_Busy
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Busy vector of outstanding load destinations plus issue-stage hazard compare.
// Latency: set/clear visible one cycle after the edge; hazard is combinational.
// Backpressure: none; hazard is the stall request to the issue stage.
// Ports: set_vld/set_reg (load issued), clr_vld/clr_reg (load returned),
//        rd_reg1/rd_reg2/dest_reg (instruction in issue), wr_vld/wr_reg
//        (write stage not yet in regfile), busy/hazard outputs.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             set_vld,
    input  reg_idx_t         set_reg,
    input  logic             clr_vld,
    input  reg_idx_t         clr_reg,
    input  reg_idx_t         rd_reg1,
    input  reg_idx_t         rd_reg2,
    input  reg_idx_t         dest_reg,
    input  logic             wr_vld,
    input  reg_idx_t         wr_reg,
    output logic [NREGS-1:0] busy,
    output logic             hazard
);
    logic [NREGS-1:0] r_Busy;
    logic [NREGS-1:0] busy_nxt;
    logic             raw_hit;
    logic             waw_hit;
    logic             wr_hit;

    // Clear first, then set, so a new load to the returning register stays busy.
    // Register 0 is hardwired and never tracked.
    always_comb begin
        busy_nxt = r_Busy;
        if (clr_vld) begin
            busy_nxt[clr_reg] = 1'b0;
        end
        if (set_vld && (set_reg != '0)) begin
            busy_nxt[set_reg] = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Busy <= '0;
        end else begin
            r_Busy <= busy_nxt;
        end
    end

    // The write stage has not reached the regfile yet and nothing bypasses it.
    always_comb begin
        raw_hit = r_Busy[rd_reg1] | r_Busy[rd_reg2];
        waw_hit = r_Busy[dest_reg];
        wr_hit  = wr_vld & (((wr_reg == rd_reg1) && (rd_reg1 != '0)) ||
                            ((wr_reg == rd_reg2) && (rd_reg2 != '0)));
    end

    assign hazard = raw_hit | waw_hit | wr_hit;
    assign busy   = r_Busy;
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load return.
// Latency: value transferred in cycle N drives the regfile write in cycle N+1.
// Backpressure: ready only to the granted side; write stage never stalls (1/cycle).
// Ports: i_Clock, i_Reset (sync, active-high), bus (wb_arbiter_if.slave).
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic         i_Clock,
    input  logic         i_Reset,
    wb_arbiter_if.slave  bus
);
    logic     r_Ptr;
    logic     grant_ld;
    logic     grant_alu;
    logic     xfer_ld;
    logic     xfer_alu;
    logic     r_RegWrite;
    reg_idx_t r_WriteReg;
    xdata_t   r_WriteData;

    // Grant depends only on the valids and the pointer, never on ready.
    always_comb begin
        grant_ld  = bus.i_LdValid  & (~bus.i_AluValid | (r_Ptr == PRIO_LD));
        grant_alu = bus.i_AluValid & (~bus.i_LdValid  | (r_Ptr == PRIO_ALU));
    end

    // Ready is held low in the reset cycle so nothing is accepted and lost.
    assign xfer_ld        = grant_ld  & ~i_Reset;
    assign xfer_alu       = grant_alu & ~i_Reset;
    assign bus.o_LdReady  = xfer_ld;
    assign bus.o_AluReady = xfer_alu;

    // Write stage: register-0 writes are accepted but not enabled.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Ptr       <= PRIO_LD;
            r_RegWrite  <= 1'b0;
            r_WriteReg  <= '0;
            r_WriteData <= '0;
        end else if (xfer_ld) begin
            r_Ptr       <= PRIO_ALU;
            r_RegWrite  <= (bus.i_LdReg != '0);
            r_WriteReg  <= bus.i_LdReg;
            r_WriteData <= bus.i_LdData;
        end else if (xfer_alu) begin
            r_Ptr       <= PRIO_LD;
            r_RegWrite  <= (bus.i_AluReg != '0);
            r_WriteReg  <= bus.i_AluReg;
            r_WriteData <= bus.i_AluData;
        end else begin
            r_RegWrite  <= 1'b0;
        end
    end

    assign bus.o_RegWrite  = r_RegWrite;
    assign bus.o_WriteReg  = r_WriteReg;
    assign bus.o_WriteData = r_WriteData;

    wb_scoreboard u_scoreboard (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .set_vld  (bus.i_LdIssue),
        .set_reg  (bus.i_LdIssueReg),
        .clr_vld  (xfer_ld),
        .clr_reg  (bus.i_LdReg),
        .rd_reg1  (bus.i_ReadReg1),
        .rd_reg2  (bus.i_ReadReg2),
        .dest_reg (bus.i_DestReg),
        .wr_vld   (r_RegWrite),
        .wr_reg   (r_WriteReg),
        .busy     (bus.o_Busy),
        .hazard   (bus.o_Hazard)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (who was served last, set of pending loads, pending write).
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus();
    wb_arbiter dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int n_warn   = 0;

    // Reference model
    bit          m_busy[32];
    bit          m_alu_last = 1'b1;   // after reset the load side goes first
    bit          m_we       = 1'b0;
    logic [4:0]  m_reg      = '0;
    logic [63:0] m_data     = '0;
    logic        exp_ld_rdy, exp_alu_rdy, exp_hazard;
    logic        obs_ld_rdy, obs_alu_rdy, obs_hazard;

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.i_AluValid = 0; bus.i_AluReg = 0; bus.i_AluData = 0;
        bus.i_LdValid = 0;  bus.i_LdReg = 0;  bus.i_LdData = 0;
        bus.i_LdIssue = 0;  bus.i_LdIssueReg = 0;
        bus.i_ReadReg1 = 0; bus.i_ReadReg2 = 0; bus.i_DestReg = 0;
    endtask

    // One clock: predict/sample combinational outputs mid-low-phase, advance model at the edge.
    task automatic cycle();
        int r1, r2, rd;
        #1;
        if (rst) begin
            exp_ld_rdy = 0; exp_alu_rdy = 0;
        end else if (bus.i_LdValid && bus.i_AluValid) begin
            exp_ld_rdy = m_alu_last; exp_alu_rdy = !m_alu_last;
        end else begin
            exp_ld_rdy = bus.i_LdValid; exp_alu_rdy = bus.i_AluValid;
        end
        r1 = int'(bus.i_ReadReg1); r2 = int'(bus.i_ReadReg2); rd = int'(bus.i_DestReg);
        exp_hazard = m_busy[r1] | m_busy[r2] | m_busy[rd] |
                     (m_we && ((int'(m_reg) == r1 && r1 != 0) || (int'(m_reg) == r2 && r2 != 0)));
        obs_ld_rdy = bus.o_LdReady; obs_alu_rdy = bus.o_AluReady; obs_hazard = bus.o_Hazard;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_alu_last = 1; m_we = 0; m_reg = 0; m_data = 0;
        end else begin
            if (exp_ld_rdy) begin
                if (!m_busy[bus.i_LdReg]) begin
                    n_warn++;
                    $display("note: load return to idle register %0d at %0t", bus.i_LdReg, $time);
                end
                m_busy[bus.i_LdReg] = 0;
                m_we = (bus.i_LdReg != 0); m_reg = bus.i_LdReg; m_data = bus.i_LdData;
                m_alu_last = 0;
            end else if (exp_alu_rdy) begin
                m_we = (bus.i_AluReg != 0); m_reg = bus.i_AluReg; m_data = bus.i_AluData;
                m_alu_last = 1;
            end else begin
                m_we = 0;
            end
            if (bus.i_LdIssue && bus.i_LdIssueReg != 0) m_busy[bus.i_LdIssueReg] = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; cycle(); cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        n_checks++; if (bus.o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", bus.o_RegWrite); end
        n_checks++; if (bus.o_Busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", bus.o_Busy); end
        n_checks++; if (bus.o_Hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", bus.o_Hazard); end
        n_checks++; if (bus.o_WriteReg !== 5'd0 || bus.o_WriteData !== 64'h0) begin n_fail++; $display("FAIL reset_wstage: got %0d/%h expected 0/0", bus.o_WriteReg, bus.o_WriteData); end
    endtask

    task automatic test_alu_only();
        bus.i_AluValid = 1; bus.i_AluReg = 5; bus.i_AluData = 64'h1234;
        cycle();
        n_checks++; if (obs_alu_rdy !== 1'b1 || obs_ld_rdy !== 1'b0) begin n_fail++; $display("FAIL alu_ready: got alu=%b ld=%b expected 1/0", obs_alu_rdy, obs_ld_rdy); end
        bus.i_AluValid = 0;
        n_checks++; if (bus.o_RegWrite !== 1'b1 || bus.o_WriteReg !== 5'd5 || bus.o_WriteData !== 64'h1234) begin n_fail++; $display("FAIL alu_write: got %b/%0d/%h expected 1/5/1234", bus.o_RegWrite, bus.o_WriteReg, bus.o_WriteData); end
        cycle();
        n_checks++; if (bus.o_RegWrite !== 1'b0 || bus.o_WriteReg !== 5'd5 || bus.o_WriteData !== 64'h1234) begin n_fail++; $display("FAIL idle_hold: got %b/%0d/%h expected 0/5/1234", bus.o_RegWrite, bus.o_WriteReg, bus.o_WriteData); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_reg;
        do_reset();
        bus.i_AluValid = 1; bus.i_AluReg = 3; bus.i_AluData = 64'hA3;
        bus.i_LdValid = 1;  bus.i_LdReg = 7;  bus.i_LdData = 64'hB7;
        for (int k = 0; k < 4; k++) begin
            cycle();
            exp_reg = (k % 2 == 0) ? 5'd7 : 5'd3;
            n_checks++; if (obs_ld_rdy !== (k % 2 == 0) || obs_alu_rdy !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_grant%0d: got ld=%b alu=%b expected ld=%b", k, obs_ld_rdy, obs_alu_rdy, k % 2 == 0); end
            n_checks++; if (bus.o_RegWrite !== 1'b1 || bus.o_WriteReg !== exp_reg) begin n_fail++; $display("FAIL rr_out%0d: got %b/%0d expected 1/%0d", k, bus.o_RegWrite, bus.o_WriteReg, exp_reg); end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_hazard_raw();
        logic exp_seq[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.i_LdIssue = 1; bus.i_LdIssueReg = 9;
        cycle();
        bus.i_LdIssue = 0; bus.i_ReadReg1 = 9;
        for (int k = 0; k < 4; k++) begin
            bus.i_LdValid = (k == 1); bus.i_LdReg = 9; bus.i_LdData = 64'h99;
            cycle();
            n_checks++; if (obs_hazard !== exp_seq[k] || obs_hazard !== exp_hazard) begin n_fail++; $display("FAIL raw_hazard%0d: got %b expected %b", k, obs_hazard, exp_seq[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        do_reset();
        bus.i_LdIssue = 1; bus.i_LdIssueReg = 4;
        cycle();
        bus.i_LdValid = 1; bus.i_LdReg = 4; bus.i_LdData = 64'h44;
        cycle();
        n_checks++; if (obs_ld_rdy !== 1'b1) begin n_fail++; $display("FAIL setwins_ready: got %b expected 1", obs_ld_rdy); end
        n_checks++; if (bus.o_Busy[4] !== 1'b1) begin n_fail++; $display("FAIL setwins_busy: got %b expected 1", bus.o_Busy[4]); end
        bus.i_LdIssue = 0;
        cycle();
        n_checks++; if (bus.o_Busy !== 32'h0) begin n_fail++; $display("FAIL setwins_clear: got %h expected 0", bus.o_Busy); end
        idle_inputs();
    endtask

    task automatic test_reg0();
        bus.i_AluValid = 1; bus.i_AluReg = 0; bus.i_AluData = 64'hFFFF;
        bus.i_LdIssue = 1;  bus.i_LdIssueReg = 0;
        cycle();
        n_checks++; if (obs_alu_rdy !== 1'b1) begin n_fail++; $display("FAIL reg0_ready: got %b expected 1", obs_alu_rdy); end
        n_checks++; if (bus.o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL reg0_write: got %b expected 0", bus.o_RegWrite); end
        n_checks++; if (bus.o_Busy !== 32'h0) begin n_fail++; $display("FAIL reg0_busy: got %h expected 0", bus.o_Busy); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.i_LdIssue = 1; bus.i_LdIssueReg = 12;
        bus.i_AluValid = 1; bus.i_AluReg = 2; bus.i_AluData = 64'h22;
        cycle();
        bus.i_LdIssue = 0; bus.i_LdValid = 1; bus.i_LdReg = 12;
        rst = 1;
        cycle();
        n_checks++; if (obs_alu_rdy !== 1'b0 || obs_ld_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got alu=%b ld=%b expected 0/0", obs_alu_rdy, obs_ld_rdy); end
        n_checks++; if (bus.o_Busy !== 32'h0 || bus.o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got busy=%h we=%b expected 0/0", bus.o_Busy, bus.o_RegWrite); end
        rst = 0;
        idle_inputs();
        cycle();
    endtask

    task automatic test_random();
        bit alu_pend = 0, ld_pend = 0;
        int pick;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!alu_pend && $urandom_range(0, 99) < 50) begin
                alu_pend = 1; bus.i_AluReg = 5'($urandom_range(0, 7)); bus.i_AluData = {$urandom, $urandom};
            end
            if (!ld_pend && $urandom_range(0, 99) < 40) begin
                ld_pend = 1; pick = $urandom_range(0, 7);
                for (int i = 1; i < 8; i++) if (m_busy[i]) pick = i;
                bus.i_LdReg = 5'(pick); bus.i_LdData = {$urandom, $urandom};
            end
            bus.i_AluValid = alu_pend; bus.i_LdValid = ld_pend;
            bus.i_LdIssue = ($urandom_range(0, 99) < 25); bus.i_LdIssueReg = 5'($urandom_range(0, 7));
            bus.i_ReadReg1 = 5'($urandom_range(0, 7)); bus.i_ReadReg2 = 5'($urandom_range(0, 7));
            bus.i_DestReg = 5'($urandom_range(0, 7));
            cycle();
            n_checks++; if (obs_ld_rdy !== exp_ld_rdy || obs_alu_rdy !== exp_alu_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got ld=%b alu=%b expected ld=%b alu=%b", c, obs_ld_rdy, obs_alu_rdy, exp_ld_rdy, exp_alu_rdy); end
            n_checks++; if (obs_hazard !== exp_hazard) begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b expected %b", c, obs_hazard, exp_hazard); end
            n_checks++; if (bus.o_RegWrite !== m_we) begin n_fail++; $display("FAIL rnd_we c%0d: got %b expected %b", c, bus.o_RegWrite, m_we); end
            n_checks++; if (bus.o_Busy !== busy_vec()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h expected %h", c, bus.o_Busy, busy_vec()); end
            if (m_we) begin
                n_checks++; if (bus.o_WriteReg !== m_reg || bus.o_WriteData !== m_data) begin n_fail++; $display("FAIL rnd_wdat c%0d: got %0d/%h expected %0d/%h", c, bus.o_WriteReg, bus.o_WriteData, m_reg, m_data); end
            end
            if (exp_alu_rdy) alu_pend = 0;
            if (exp_ld_rdy)  ld_pend = 0;
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_only();
        test_round_robin();
        test_hazard_raw();
        test_set_wins();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
